// File: rtl/switch_debounce_if.sv
// Switch pin/debounced-word bundle between board pins, filter and switch reader.
// Latency: none, wires only.
// Backpressure: none, the debounced word is a level and is always valid to read.
interface switch_debounce_if #(
    parameter int WIDTH = 24
);
    logic [WIDTH-1:0] switch_raw;
    logic [WIDTH-1:0] switch_input;
    logic             switch_changed;
    logic             switch_valid;

    // Filter side: takes raw pins, produces the clean word and status.
    modport master (
        input  switch_raw,
        output switch_input,
        output switch_changed,
        output switch_valid
    );

    // Pin/consumer side: drives raw pins, reads the clean word and status.
    modport slave (
        output switch_raw,
        input  switch_input,
        input  switch_changed,
        input  switch_valid
    );
endinterface

// File: rtl/switch_debounce.sv
// Per-bit 2-FF synchronizer plus tick-sampled stability filter for board DIP switches.
// Latency: 2 + (STABLE_TICKS-1)*TICK_DIV + 1 .. 2 + STABLE_TICKS*TICK_DIV + 1 clocks from a steady raw edge.
// Backpressure: none, the output is a level refreshed only on sample ticks.
module switch_debounce #(
    parameter int WIDTH        = 24,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 5
) (
    input  logic                switclk,
    input  logic                switchrst,
    switch_debounce_if.master   sw
);

    localparam int         PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [3:0] ST       = 4'(STABLE_TICKS);
    localparam logic [3:0] ST_M1    = 4'(STABLE_TICKS - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    // Synchronizer stages; only s2 is safe to look at.
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    // Sample-tick prescaler.
    logic [PW-1:0]    prescale;
    logic             tick;

    // Per-bit candidate value and run length of equal samples.
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] cand_nxt;
    logic [3:0]       cnt     [WIDTH];
    logic [3:0]       cnt_nxt [WIDTH];

    // Debounced word and its next value.
    logic [WIDTH-1:0] clean;
    logic [WIDTH-1:0] clean_nxt;
    logic             changed;

    // Post-reset settle tracking.
    logic [3:0]       settle;
    logic             valid;

    assign tick = (prescale == PRE_LAST);

    // Two-flop synchronizer for the asynchronous switch pins.
    always_ff @(posedge switclk) begin
        if (switchrst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw.switch_raw;
            s2 <= s1;
        end
    end

    // Prescaler counting 0..TICK_DIV-1; tick is its last count.
    always_ff @(posedge switclk) begin
        if (switchrst) begin
            prescale <= '0;
        end else if (tick) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

    // Per-bit filter decision: restart on a differing sample, count up on an
    // equal one, commit when the run reaches STABLE_TICKS, then saturate.
    always_comb begin
        cand_nxt  = cand;
        clean_nxt = clean;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = cnt[i];
        end
        if (tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s2[i] != cand[i]) begin
                    cand_nxt[i] = s2[i];
                    cnt_nxt[i]  = 4'd1;
                end else if (cnt[i] == ST_M1) begin
                    cnt_nxt[i]   = ST;
                    clean_nxt[i] = cand[i];
                end else if (cnt[i] < ST_M1) begin
                    cnt_nxt[i] = cnt[i] + 4'd1;
                end
            end
        end
    end

    // Filter state registers; counts start saturated so a low pin needs no commit.
    always_ff @(posedge switclk) begin
        if (switchrst) begin
            cand <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= ST;
            end
        end else begin
            cand <= cand_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // Debounced word plus a pulse only when a commit actually flips a bit.
    always_ff @(posedge switclk) begin
        if (switchrst) begin
            clean   <= '0;
            changed <= 1'b0;
        end else begin
            clean   <= clean_nxt;
            changed <= (clean_nxt != clean);
        end
    end

    // Settle counter: valid rises on the tick where it reaches STABLE_TICKS,
    // the same tick a pin held high through reset commits.
    always_ff @(posedge switclk) begin
        if (switchrst) begin
            settle <= 4'd0;
            valid  <= 1'b0;
        end else if (tick && (settle < ST)) begin
            settle <= settle + 4'd1;
            if (settle == ST_M1) begin
                valid <= 1'b1;
            end
        end
    end

    assign sw.switch_input   = clean;
    assign sw.switch_changed = changed;
    assign sw.switch_valid   = valid;

endmodule

// File: tb/tb_switch_debounce.sv
// Randomized and directed bench for switch_debounce against a sample-history model.
// Latency: checks every cycle on the falling edge.
// Backpressure: none.
module tb_switch_debounce;

    localparam int W  = 24;
    localparam int TD = 4;
    localparam int ST = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    switch_debounce_if #(.WIDTH(W)) sw ();

    switch_debounce #(
        .WIDTH       (W),
        .TICK_DIV    (TD),
        .STABLE_TICKS(ST)
    ) dut (
        .switclk  (clk),
        .switchrst(rst),
        .sw       (sw.master)
    );

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%h exp=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: remembers the word seen on the last ST sample ticks
    // (pins delayed two clocks); a bit takes a value once all remembered
    // samples agree on it, with ST samples needed after reset.
    logic [W-1:0] m_d1, m_d2;
    logic [W-1:0] hist [ST];
    int           m_cyc;
    int           m_nsamp;
    logic [W-1:0] m_in;
    logic         m_chg;
    logic         m_vld;
    bit           model_ok = 0;

    always @(posedge clk) begin
        logic [W-1:0] agree;
        logic [W-1:0] nxt;
        if (rst) begin
            m_d1 = '0;
            m_d2 = '0;
            m_cyc = 0;
            m_nsamp = 0;
            m_in = '0;
            m_chg = 1'b0;
            m_vld = 1'b0;
            for (int k = 0; k < ST; k++) hist[k] = '0;
            model_ok = 1;
        end else begin
            m_chg = 1'b0;
            if ((m_cyc % TD) == TD - 1) begin
                for (int k = ST - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = m_d2;
                if (m_nsamp < ST) m_nsamp++;
                if (m_nsamp >= ST) begin
                    agree = '1;
                    for (int k = 1; k < ST; k++) agree &= ~(hist[k] ^ hist[0]);
                    nxt   = (m_in & ~agree) | (hist[0] & agree);
                    m_chg = (nxt != m_in);
                    m_in  = nxt;
                    m_vld = 1'b1;
                end
            end
            m_cyc++;
            m_d2 = m_d1;
            m_d1 = sw.switch_raw;
        end
    end

    // Every-cycle comparison against the model, plus pulse counting.
    always @(negedge clk) begin
        if (model_ok) begin
            check_val("input",   32'(sw.switch_input),   32'(m_in));
            check_val("changed", 32'(sw.switch_changed), 32'(m_chg));
            check_val("valid",   32'(sw.switch_valid),   32'(m_vld));
            if (sw.switch_changed === 1'b1) pulses++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic settle_zero();
        sw.switch_raw = '0;
        cyc(20);
    endtask

    // Counts clocks until valid rises; -1 if it never does within the bound.
    task automatic wait_valid(output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            cyc(1);
            if (sw.switch_valid === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n;
        bit found;
        logic [W-1:0] tgt;

        // 1: reset held with all pins high, then first commit alongside valid.
        sw.switch_raw = 24'hFFFFFF;
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        pulses = 0;
        wait_valid(n);
        check_val("t1_valid_lat", 32'(n), 32'd12);
        check_val("t1_input", 32'(sw.switch_input), 32'h00FFFFFF);
        cyc(20);
        check_val("t1_pulses", 32'(pulses), 32'd1);

        // 2: clean step, latency window and a single pulse.
        settle_zero();
        pulses = 0;
        tgt = 24'h00A5A5;
        sw.switch_raw = tgt;
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            cyc(1);
            if (sw.switch_input === tgt) begin
                n = k;
                break;
            end
        end
        check_val("t2_lat_in_window", 32'((n >= 11) && (n <= 15)), 32'd1);
        cyc(20);
        check_val("t2_input", 32'(sw.switch_input), 32'(tgt));
        check_val("t2_pulses", 32'(pulses), 32'd1);

        // 3: bounce bit 0 with period 3; no three equal samples in a row.
        settle_zero();
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            sw.switch_raw[0] = ((k % 3) != 2);
            cyc(1);
        end
        check_val("t3_bounce_held", 32'(sw.switch_input[0]), 32'd0);
        check_val("t3_bounce_pulses", 32'(pulses), 32'd0);
        sw.switch_raw[0] = 1'b1;
        cyc(25);
        check_val("t3_final", 32'(sw.switch_input[0]), 32'd1);
        check_val("t3_pulses", 32'(pulses), 32'd1);

        // 4: one tick window glitch on bit 23.
        settle_zero();
        pulses = 0;
        sw.switch_raw[23] = 1'b1;
        cyc(TD);
        sw.switch_raw[23] = 1'b0;
        cyc(30);
        check_val("t4_bit23", 32'(sw.switch_input[23]), 32'd0);
        check_val("t4_pulses", 32'(pulses), 32'd0);

        // 5: two bits rising together commit together.
        settle_zero();
        pulses = 0;
        tgt = (24'd1 << 5) | (24'd1 << 17);
        sw.switch_raw = tgt;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            cyc(1);
            if (sw.switch_input !== '0) begin
                found = 1;
                break;
            end
        end
        check_val("t5_found", 32'(found), 32'd1);
        check_val("t5_same_tick", 32'(sw.switch_input), 32'(tgt));
        cyc(20);
        check_val("t5_pulses", 32'(pulses), 32'd1);

        // 6: reset while bit 9 has two equal samples, then a full restart.
        settle_zero();
        sw.switch_raw = 24'd1 << 9;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            cyc(1);
            if (hist[0][9] && hist[1][9]) begin
                found = 1;
                break;
            end
        end
        check_val("t6_reached_cnt2", 32'(found), 32'd1);
        check_val("t6_not_yet", 32'(sw.switch_input[9]), 32'd0);
        rst = 1'b1;
        cyc(1);
        check_val("t6_rst_input", 32'(sw.switch_input), 32'd0);
        check_val("t6_rst_changed", 32'(sw.switch_changed), 32'd0);
        check_val("t6_rst_valid", 32'(sw.switch_valid), 32'd0);
        rst = 1'b0;
        wait_valid(n);
        check_val("t6_restart_lat", 32'(n), 32'd12);
        check_val("t6_restart_input", 32'(sw.switch_input), 32'(24'd1 << 9));

        // Random pin activity with occasional resets; model checks every cycle.
        for (int k = 0; k < 1500; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                sw.switch_raw = sw.switch_raw ^ (24'd1 << $urandom_range(0, W - 1));
            end else if (r == 2 && $urandom_range(0, 7) == 0) begin
                sw.switch_raw = 24'($urandom);
            end
            rst = ($urandom_range(0, 299) == 0);
            cyc(1);
        end
        rst = 1'b0;
        cyc(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
